// File: rtl/add_pkg.sv
// add_pkg: shared defaults, opcode and flag types for the pipelined adder/subtractor
package add_pkg;
   localparam int ADD_WIDTH  = 16;
   localparam int ADD_STAGES = 4;
   typedef enum logic {OP_ADD, OP_SUB} add_op_t;
   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
      logic neg;
   } add_flags_t;
endpackage

// File: rtl/pipelined_add_sub_if.sv
// pipelined_add_sub_if: operand/result valid-ready bundle for pipelined_add_sub
interface pipelined_add_sub_if #(parameter int WIDTH = add_pkg::ADD_WIDTH);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;
   logic             neg;
   modport master (
      output in_valid, op_a, op_b, sub, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero, neg
   );
   modport slave (
      input  in_valid, op_a, op_b, sub, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero, neg
   );
endinterface

// File: rtl/add_segment.sv
// add_segment: combinational SEG-bit ripple slice reporting carry out and carry into its MSB
module add_segment #(parameter int SEG = 4) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout,
   output logic           cmsb
);
   always_comb begin
      {cout, sum} = {1'b0, a} + {1'b0, b} + (SEG+1)'(cin);
      cmsb = a[SEG-1] ^ b[SEG-1] ^ sum[SEG-1];
   end
endmodule

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: segmented carry-chain add/sub, one segment per pipeline stage,
// behind a valid/ready handshake with a global stall.
module pipelined_add_sub
   import add_pkg::*;
#(
   parameter int WIDTH  = ADD_WIDTH,
   parameter int STAGES = ADD_STAGES
) (
   input logic clk,
   input logic rst_n,
   pipelined_add_sub_if.slave bus
);
   localparam int SEG = WIDTH / STAGES;
   add_op_t           op;
   add_flags_t        flags;
   logic              adv;
   logic [WIDTH-1:0]  a_in [STAGES];
   logic [WIDTH-1:0]  b_in [STAGES];
   logic [WIDTH-1:0]  s_in [STAGES];
   logic [STAGES-1:0] c_in, z_in, v_in;
   logic [SEG-1:0]    seg_s [STAGES];
   logic [STAGES-1:0] seg_co;
   logic              seg_cm [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [STAGES-1:0] c_d, c_q, z_d, z_q, v_d, v_q;
   logic              ovf_d, ovf_q;

   assign op  = add_op_t'(bus.sub);
   assign adv = !v_q[STAGES-1] || bus.out_ready;

   // operands shift right one segment per stage; finished sum segments shift in from the top
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign a_in[k] = bus.op_a;
         assign b_in[k] = op == OP_SUB ? ~bus.op_b : bus.op_b;
         assign s_in[k] = '0;
         assign c_in[k] = op == OP_SUB ? ~bus.cin : bus.cin;
         assign z_in[k] = 1'b1;
         assign v_in[k] = bus.in_valid;
      end else begin : g_tail
         assign a_in[k] = a_q[k-1];
         assign b_in[k] = b_q[k-1];
         assign s_in[k] = s_q[k-1];
         assign c_in[k] = c_q[k-1];
         assign z_in[k] = z_q[k-1];
         assign v_in[k] = v_q[k-1];
      end
      add_segment #(.SEG(SEG)) u_seg (
         .a    (a_in[k][SEG-1:0]),
         .b    (b_in[k][SEG-1:0]),
         .cin  (c_in[k]),
         .sum  (seg_s[k]),
         .cout (seg_co[k]),
         .cmsb (seg_cm[k])
      );
   end

   always_comb begin
      for (int i = 0; i < STAGES; i++) begin
         a_d[i] = a_in[i] >> SEG;
         b_d[i] = b_in[i] >> SEG;
         s_d[i] = (s_in[i] >> SEG) | (WIDTH'(seg_s[i]) << (WIDTH - SEG));
         c_d[i] = seg_co[i];
         z_d[i] = z_in[i] && seg_s[i] == '0;
         v_d[i] = v_in[i];
      end
      ovf_d = seg_cm[STAGES-1] ^ seg_co[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '{default: '0};
         b_q   <= '{default: '0};
         s_q   <= '{default: '0};
         c_q   <= '0;
         z_q   <= '0;
         v_q   <= '0;
         ovf_q <= 1'b0;
      end else if (adv) begin
         a_q   <= a_d;
         b_q   <= b_d;
         s_q   <= s_d;
         c_q   <= c_d;
         z_q   <= z_d;
         v_q   <= v_d;
         ovf_q <= ovf_d;
      end
   end

   assign flags = '{cout: c_q[STAGES-1], ovf: ovf_q, zero: z_q[STAGES-1], neg: s_q[STAGES-1][WIDTH-1]};
   assign {bus.cout, bus.ovf, bus.zero, bus.neg} = flags;
   assign bus.sum       = s_q[STAGES-1];
   assign bus.out_valid = v_q[STAGES-1];
   assign bus.in_ready  = adv;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed and randomized checks of pipelined_add_sub
// against a plain-arithmetic reference model and a fixed-length delay-line view of the pipe.
module tb_pipelined_add_sub;
   localparam int W = 16;
   localparam int S = 4;
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic         c;
   } op_t;
   typedef struct {
      logic v;
      op_t  o;
   } slot_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   int n, sent, got;
   op_t ops [8];
   op_t cur;
   slot_t pipe [$];
   logic exp_ov, exp_adv, stalled;
   logic [W+3:0] held;

   pipelined_add_sub_if #(.WIDTH(W)) bus ();
   pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // {cout, ovf, zero, neg, sum} from unbounded integer arithmetic
   function automatic logic [W+3:0] model(op_t o);
      int r, sr;
      logic [W-1:0] sm;
      logic co, ov;
      r  = o.s ? int'(o.a) - int'(o.b) - int'(o.c) : int'(o.a) + int'(o.b) + int'(o.c);
      sr = o.s ? int'($signed(o.a)) - int'($signed(o.b)) - int'(o.c)
               : int'($signed(o.a)) + int'($signed(o.b)) + int'(o.c);
      sm = W'(r);
      co = o.s ? r >= 0 : r >= (1 << W);
      ov = sr > (1 << (W-1)) - 1 || sr < -(1 << (W-1));
      return {co, ov, sm == '0, sm[W-1], sm};
   endfunction

   function automatic logic [W+3:0] obs();
      return {bus.cout, bus.ovf, bus.zero, bus.neg, bus.sum};
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic drive(input op_t o, input logic iv, input logic ordy);
      bus.in_valid  = iv;
      bus.op_a      = o.a;
      bus.op_b      = o.b;
      bus.sub       = o.s;
      bus.cin       = o.c;
      bus.out_ready = ordy;
   endtask

   task automatic directed(input string tag, input op_t o, input logic [W+3:0] exp);
      @(negedge clk);
      drive(o, 1'b1, 1'b1);
      #1 check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(1));
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      check({tag, "_latency"}, 32'(n), 32'(S));
      check({tag, "_result"}, 32'(obs()), 32'(exp));
      @(posedge clk);
      #1 check({tag, "_drained"}, 32'(bus.out_valid), 32'(0));
   endtask

   initial begin
      drive('{a: '0, b: '0, s: 1'b0, c: 1'b0}, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      check("rst_hold_out_valid", 32'(bus.out_valid), 32'(0));
      check("rst_hold_in_ready", 32'(bus.in_ready), 32'(1));
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'(0));
      check("rst_sum_flags", 32'(obs()), 32'(0));
      check("rst_in_ready", 32'(bus.in_ready), 32'(1));

      directed("add_wrap", '{a: 16'hFFFF, b: 16'h0001, s: 1'b0, c: 1'b0}, {4'b1010, 16'h0000});
      directed("add_ovf",  '{a: 16'h7FFF, b: 16'h0001, s: 1'b0, c: 1'b0}, {4'b0101, 16'h8000});
      directed("add_cin",  '{a: 16'h1234, b: 16'h0000, s: 1'b0, c: 1'b1}, {4'b0000, 16'h1235});
      directed("sub_neg",  '{a: 16'h0005, b: 16'h0007, s: 1'b1, c: 1'b0}, {4'b0001, 16'hFFFE});
      directed("sub_ovf",  '{a: 16'h8000, b: 16'h0001, s: 1'b1, c: 1'b0}, {4'b1100, 16'h7FFF});

      // random stream with out_ready low for three cycles mid-stream
      for (int i = 0; i < 8; i++)
         ops[i] = '{a: W'($urandom), b: W'($urandom), s: 1'($urandom), c: 1'($urandom)};
      pipe = {};
      repeat (S) pipe.push_back('{v: 1'b0, o: ops[0]});
      sent = 0;
      got = 0;
      stalled = 1'b0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         @(negedge clk);
         cur = ops[sent < 8 ? sent : 7];
         drive(cur, sent < 8, !(cyc >= 5 && cyc <= 7));
         #1;
         exp_ov  = pipe[0].v;
         exp_adv = !exp_ov || bus.out_ready;
         check("stream_out_valid", 32'(bus.out_valid), 32'(exp_ov));
         check("stream_in_ready", 32'(bus.in_ready), 32'(exp_adv));
         if (exp_ov && bus.out_ready) begin
            check("stream_result", 32'(obs()), 32'(model(pipe[0].o)));
            got++;
         end
         if (exp_ov && !bus.out_ready) begin
            if (stalled) check("stream_stall_hold", 32'(obs()), 32'(held));
            held = obs();
            stalled = 1'b1;
         end else stalled = 1'b0;
         if (exp_adv) begin
            void'(pipe.pop_front());
            pipe.push_back('{v: bus.in_valid, o: cur});
            if (bus.in_valid) sent++;
         end
      end
      check("stream_count", 32'(got), 32'(8));
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 check("stream_drained", 32'(bus.out_valid), 32'(0));

      // asynchronous reset with three operations in flight
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(ops[i], 1'b1, 1'b0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 10) begin
         @(posedge clk);
         #1 n++;
      end
      check("rst_inflight_valid", 32'(bus.out_valid), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_out_valid", 32'(bus.out_valid), 32'(0));
      check("rst_async_in_ready", 32'(bus.in_ready), 32'(1));
      check("rst_async_sum_flags", 32'(obs()), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("rst_no_stale", 32'(bus.out_valid), 32'(0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
